// File: rtl/teclado_pkg.sv
// Shared definitions for the PS/2 keypad validator.
// Holds scan-code constants, key-index constants, the prefix FSM state
// encoding and the make-code decoder used by validador_tecla_buffer.
package teclado_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam logic [3:0] K_0     = 4'd0;
  localparam logic [3:0] K_1     = 4'd1;
  localparam logic [3:0] K_2     = 4'd2;
  localparam logic [3:0] K_3     = 4'd3;
  localparam logic [3:0] K_4     = 4'd4;
  localparam logic [3:0] K_5     = 4'd5;
  localparam logic [3:0] K_6     = 4'd6;
  localparam logic [3:0] K_7     = 4'd7;
  localparam logic [3:0] K_8     = 4'd8;
  localparam logic [3:0] K_9     = 4'd9;
  localparam logic [3:0] K_A     = 4'd10;
  localparam logic [3:0] K_B     = 4'd11;
  localparam logic [3:0] K_C     = 4'd12;
  localparam logic [3:0] K_ENTER = 4'd13;

  typedef enum logic [1:0] {
    REPOSO,
    RUPTURA,
    EXTENDIDO,
    EXT_RUPTURA
  } estado_t;

  // Returns {valid, key_index} for a non-prefixed scan code.
  function automatic logic [4:0] decodifica(input logic [7:0] sc, input logic keypad);
    logic [4:0] r;
    r = '0;
    case (sc)
      8'h45: r = {1'b1, K_0};
      8'h16: r = {1'b1, K_1};
      8'h1E: r = {1'b1, K_2};
      8'h26: r = {1'b1, K_3};
      8'h25: r = {1'b1, K_4};
      8'h2E: r = {1'b1, K_5};
      8'h36: r = {1'b1, K_6};
      8'h3D: r = {1'b1, K_7};
      8'h3E: r = {1'b1, K_8};
      8'h46: r = {1'b1, K_9};
      8'h43: r = {1'b1, K_A};
      8'h4D: r = {1'b1, K_B};
      8'h31: r = {1'b1, K_C};
      8'h5A: r = {1'b1, K_ENTER};
      8'h70: r = {keypad, K_0};
      8'h69: r = {keypad, K_1};
      8'h72: r = {keypad, K_2};
      8'h7A: r = {keypad, K_3};
      8'h6B: r = {keypad, K_4};
      8'h73: r = {keypad, K_5};
      8'h74: r = {keypad, K_6};
      8'h6C: r = {keypad, K_7};
      8'h75: r = {keypad, K_8};
      8'h7D: r = {keypad, K_9};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fifo_teclas.sv
// First-word-fall-through FIFO of 4-bit key indices.
// Ports: clk, rst (async, active-high), push/din write side, pop read side,
// dout = head entry (0 when empty), empty, full, count = occupancy 0..DEPTH.
// A push while full is accepted only if a pop happens in the same cycle.
module fifo_teclas #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [3:0]               din,
  input  logic                     pop,
  output logic [3:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  import teclado_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop_ok, push_ok;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    // Pointers are AW bits wide so the increments wrap modulo DEPTH.
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    dout     = empty ? '0 : mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/validador_tecla_buffer.sv
// PS/2 scan-code validator with key buffer.
// Decodes make codes (with F0 break and E0 extended prefixes) into 4-bit key
// indices, suppresses typematic repeats of a held key, and buffers accepted
// keys in a FWFT FIFO.
// Ports: clk, rst (async, active-high), dato/tick scan-code input,
// rd_en pop, clr_ovf clears sticky overflow; outputs tecla (head key),
// vacio, lleno, overflow, cuenta (occupancy).
module validador_tecla_buffer #(
  parameter int   DEPTH     = 8,
  parameter logic KEYPAD_EN = 1'b1,
  parameter logic EXT_EN    = 1'b1,
  parameter logic REPEAT_EN = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             dato,
  input  logic                   tick,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [3:0]             tecla,
  output logic                   vacio,
  output logic                   lleno,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] cuenta
);
  import teclado_pkg::*;

  estado_t    estado_q, estado_d;
  logic       held_q, held_d;
  logic [3:0] held_idx_q, held_idx_d;
  logic       overflow_q, overflow_d;

  logic [4:0] dec;
  logic       make_valid, brk_valid, push;
  logic [3:0] make_idx, brk_idx;

  always_comb begin
    estado_d   = estado_q;
    held_d     = held_q;
    held_idx_d = held_idx_q;
    make_valid = 1'b0;
    make_idx   = '0;
    brk_valid  = 1'b0;
    brk_idx    = '0;
    push       = 1'b0;
    dec        = decodifica(dato, KEYPAD_EN);

    if (tick) begin
      case (estado_q)
        REPOSO: begin
          if (dato == SC_BREAK)    estado_d = RUPTURA;
          else if (dato == SC_EXT) estado_d = EXTENDIDO;
          else begin
            estado_d   = REPOSO;
            make_valid = dec[4];
            make_idx   = dec[3:0];
          end
        end
        EXTENDIDO: begin
          if (dato == SC_BREAK) estado_d = EXT_RUPTURA;
          else begin
            estado_d   = REPOSO;
            make_valid = EXT_EN && (dato == SC_ENTER);
            make_idx   = K_ENTER;
          end
        end
        RUPTURA: begin
          estado_d  = REPOSO;
          brk_valid = dec[4];
          brk_idx   = dec[3:0];
        end
        EXT_RUPTURA: begin
          estado_d  = REPOSO;
          brk_valid = EXT_EN && (dato == SC_ENTER);
          brk_idx   = K_ENTER;
        end
        default: estado_d = REPOSO;
      endcase
    end

    if (brk_valid && held_q && (brk_idx == held_idx_q)) held_d = 1'b0;

    // The held key is recorded even if the FIFO later drops it as overflow.
    if (make_valid && (REPEAT_EN || !held_q || (make_idx != held_idx_q))) begin
      push       = 1'b1;
      held_d     = 1'b1;
      held_idx_d = make_idx;
    end

    // A new overflow event takes priority over a simultaneous clear.
    overflow_d = (overflow_q & ~clr_ovf) | (push & lleno & ~(rd_en & ~vacio));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= REPOSO;
      held_q     <= 1'b0;
      held_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      held_q     <= held_d;
      held_idx_q <= held_idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  fifo_teclas #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (make_idx),
    .pop   (rd_en),
    .dout  (tecla),
    .empty (vacio),
    .full  (lleno),
    .count (cuenta)
  );

endmodule

// File: tb/tb_validador_tecla_buffer.sv
// Scoreboard bench for validador_tecla_buffer: expected keys are queued as
// stimulus is issued; a negedge monitor checks tecla on every real pop.
module tb_validador_tecla_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dato = '0;
  logic       tick = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] tecla;
  logic       vacio, lleno, overflow;
  logic [3:0] cuenta;

  logic       tick_b = 1'b0;
  logic       rd_en_b = 1'b0;
  logic       clr_b = 1'b0;
  logic [3:0] tecla_b;
  logic       vacio_b, lleno_b, overflow_b;
  logic [3:0] cuenta_b;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  validador_tecla_buffer #(.DEPTH(8), .KEYPAD_EN(1'b1), .EXT_EN(1'b1), .REPEAT_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .dato(dato), .tick(tick), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .tecla(tecla), .vacio(vacio), .lleno(lleno), .overflow(overflow), .cuenta(cuenta)
  );

  validador_tecla_buffer #(.DEPTH(8), .KEYPAD_EN(1'b0), .EXT_EN(1'b1), .REPEAT_EN(1'b0)) dut_nokp (
    .clk(clk), .rst(rst), .dato(dato), .tick(tick_b), .rd_en(rd_en_b), .clr_ovf(clr_b),
    .tecla(tecla_b), .vacio(vacio_b), .lleno(lleno_b), .overflow(overflow_b), .cuenta(cuenta_b)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: inputs change at posedge+1, so at negedge rd_en/vacio/tecla
  // describe exactly the pop that the next rising edge performs.
  always @(negedge clk) begin
    if (!rst && rd_en && !vacio) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got tecla %0d expected no entry", tecla);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (tecla !== e) begin
          n_fail++;
          $display("FAIL pop_tecla: got %0d expected %0d", tecla, e);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    dato = b; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    dato = b; tick_b = 1'b1;
    @(posedge clk); #1;
    tick_b = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    rd_en = 1'b1;
    while (!vacio && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    rd_en = 1'b0;
    chk({name, "_vacio"}, int'(vacio), 1);
    chk({name, "_tecla0"}, int'(tecla), 0);
    chk({name, "_sb_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vacio", int'(vacio), 1);
    chk("rst_lleno", int'(lleno), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_cuenta", int'(cuenta), 0);
    chk("rst_tecla", int'(tecla), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Make, break, make: 16 -> 1, F0 16 not pushed, 45 -> 0
    exp_q.push_back(4'd1); send(8'h16);
    chk("lat_vacio", int'(vacio), 0);
    send(8'hF0); send(8'h16);
    exp_q.push_back(4'd0); send(8'h45);
    chk("brk_cuenta", int'(cuenta), 2);
    drain("brk");

    // Typematic repeat suppression
    exp_q.push_back(4'd2); send(8'h1E);
    send(8'h1E); send(8'h1E);
    send(8'hF0); send(8'h1E);
    exp_q.push_back(4'd2); send(8'h1E);
    chk("rep_cuenta", int'(cuenta), 2);
    drain("rep");

    // Fill to DEPTH, ninth make overflows
    begin
      logic [7:0] codes[9];
      codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
      for (int i = 0; i < 9; i++) begin
        if (i < 8) exp_q.push_back(4'(i));
        send(codes[i]);
      end
    end
    chk("full_lleno", int'(lleno), 1);
    chk("full_cuenta", int'(cuenta), 8);
    chk("full_ovf", int'(overflow), 1);
    chk("full_head", int'(tecla), 0);
    clr_ovf = 1'b1; @(posedge clk); #1; clr_ovf = 1'b0;
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_cuenta", int'(cuenta), 8);
    // Overflow event coinciding with clear keeps overflow set
    clr_ovf = 1'b1; send(8'h46); clr_ovf = 1'b0;
    chk("clr_vs_ovf", int'(overflow), 1);
    clr_ovf = 1'b1; @(posedge clk); #1; clr_ovf = 1'b0;
    chk("clr_ovf2", int'(overflow), 0);

    // Push and pop together while full
    exp_q.push_back(4'd13);
    dato = 8'h5A; tick = 1'b1; rd_en = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; rd_en = 1'b0;
    chk("pp_cuenta", int'(cuenta), 8);
    chk("pp_ovf", int'(overflow), 0);
    chk("pp_head", int'(tecla), 1);
    drain("pp");

    // Extended codes: release 13 first, then E0 5A and E0 70
    send(8'hF0); send(8'h5A);
    exp_q.push_back(4'd13); send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'h70);
    chk("ext_cuenta", int'(cuenta), 1);
    exp_q.push_back(4'd0); send(8'h70);
    chk("kp_cuenta", int'(cuenta), 2);
    drain("ext");
    send_b(8'h70);
    chk("nokp_70", int'(cuenta_b), 0);
    send_b(8'h45);
    chk("nokp_45", int'(cuenta_b), 1);

    // Reset mid-sequence after E0 with 3 buffered keys
    exp_q.push_back(4'd1); send(8'h16);
    exp_q.push_back(4'd2); send(8'h1E);
    exp_q.push_back(4'd3); send(8'h26);
    chk("pre_rst_cuenta", int'(cuenta), 3);
    send(8'hE0);
    rst = 1'b1; #1;
    chk("async_vacio", int'(vacio), 1);
    chk("async_cuenta", int'(cuenta), 0);
    chk("async_nokp", int'(cuenta_b), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(4'd13); send(8'h5A);
    chk("post_rst_cuenta", int'(cuenta), 1);
    chk("post_rst_tecla", int'(tecla), 13);
    drain("post_rst");

    // Pop on empty is ignored
    rd_en = 1'b1; @(posedge clk); #1; rd_en = 1'b0;
    chk("empty_rd_cuenta", int'(cuenta), 0);
    chk("empty_rd_vacio", int'(vacio), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
